// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
//
// Program-counter unit for the 16-bit RISC core. Provides increment,
// absolute jump, relative branch, call/return through a hardware
// return-address stack, and a soft-reset vector. It also reports sticky
// stack overflow and underflow errors.
//
// All state updates happen on the FALLING edge of i_clk. This keeps the
// outputs stable across the rising edge for downstream rising-edge logic.
//
// Parameters
//   PC_W      PC / address width in bits
//   OFF_W     width of the signed relative-branch offset (OFF_W <= PC_W)
//   DEPTH     return-address stack entries (power of two, >= 2)
//   RESET_VEC PC value after hardware reset and after soft reset
//
// Ports
//   i_clk     clock; state updates on the falling edge
//   i_rst_n   asynchronous active-low reset
//   i_op      operation code:
//               000 HOLD, 001 INC, 010 JMP, 011 SRST,
//               100 BREL, 101 CALL, 110 RET, 111 reserved (HOLD)
//   i_target  absolute jump / call target
//   i_offset  two's-complement branch offset
//   i_stall   (PC_STALL_EN only) forces the edge to behave as HOLD
//   o_pc      current program counter (registered)
//   o_sp      number of valid stack entries (registered)
//   o_full    o_sp == DEPTH
//   o_empty   o_sp == 0
//   o_ovf     sticky: CALL issued while the stack was full
//   o_unf     sticky: RET issued while the stack was empty
//
// Build option
//   PC_STALL_EN  when defined, adds the i_stall port and the stall behaviour.
// ---------------------------------------------------------------------------
module pc_stack_unit #(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     OFF_W     = 8,
  parameter int unsigned     DEPTH     = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [2:0]              i_op,
  input  logic [PC_W-1:0]         i_target,
  input  logic [OFF_W-1:0]        i_offset,
`ifdef PC_STALL_EN
  input  logic                    i_stall,
`endif
  output logic [PC_W-1:0]         o_pc,
  output logic [$clog2(DEPTH):0]  o_sp,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_ovf,
  output logic                    o_unf
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_INC  = 3'b001,
    OP_JMP  = 3'b010,
    OP_SRST = 3'b011,
    OP_BREL = 3'b100,
    OP_CALL = 3'b101,
    OP_RET  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  // -------------------------------------------------------------------------
  // Arithmetic helpers. All PC arithmetic wraps modulo 2^PC_W, so no carry
  // is kept.
  // -------------------------------------------------------------------------
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

  // Sign-extend the branch offset to PC width, then add with wrap-around.
  function automatic logic [PC_W-1:0] pc_rel(input logic [PC_W-1:0]  pc,
                                             input logic [OFF_W-1:0] off);
    logic signed [OFF_W-1:0] off_s;
    logic signed [PC_W-1:0]  off_x;
    off_s = $signed(off);
    off_x = PC_W'(off_s);
    return pc + $unsigned(off_x);
  endfunction

  function automatic logic [SP_W-1:0] sp_inc(input logic [SP_W-1:0] sp);
    return sp + SP_W'(1);
  endfunction

  function automatic logic [SP_W-1:0] sp_dec(input logic [SP_W-1:0] sp);
    return sp - SP_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PC_W-1:0] pc_q;
  logic [SP_W-1:0] sp_q;
  logic            ovf_q;
  logic            unf_q;

  // The return-address array holds data only. It is never reset; the
  // valid entries are defined by sp_q alone.
  logic [PC_W-1:0] stack_mem [DEPTH];

  logic            full;
  logic            empty;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic [PC_W-1:0]  pop_data;

  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == '0);
  // When the stack is full, push_idx wraps to 0. No push happens in that
  // case, so the wrapped index is never used.
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_dec(sp_q));
  assign pop_data = stack_mem[pop_idx];

  // -------------------------------------------------------------------------
  // Operation decode: next-state computation
  // -------------------------------------------------------------------------
  logic            exec;
  logic [PC_W-1:0] pc_nxt;
  logic [SP_W-1:0] sp_nxt;
  logic            ovf_nxt;
  logic            unf_nxt;
  logic            push_en;

`ifdef PC_STALL_EN
  assign exec = ~i_stall;
`else
  assign exec = 1'b1;
`endif

  always_comb begin
    pc_nxt  = pc_q;
    sp_nxt  = sp_q;
    ovf_nxt = ovf_q;
    unf_nxt = unf_q;
    push_en = 1'b0;
    if (exec) begin
      case (op_e'(i_op))
        OP_INC:  pc_nxt = pc_inc(pc_q);
        OP_JMP:  pc_nxt = i_target;
        OP_SRST: begin
          pc_nxt  = RESET_VEC;
          sp_nxt  = '0;
          ovf_nxt = 1'b0;
          unf_nxt = 1'b0;
        end
        OP_BREL: pc_nxt = pc_rel(pc_q, i_offset);
        OP_CALL: begin
          // The jump is taken even when the push has to be dropped.
          pc_nxt = i_target;
          if (full) begin
            ovf_nxt = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_nxt  = sp_inc(sp_q);
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_nxt = 1'b1;
          end else begin
            pc_nxt = pop_data;
            sp_nxt = sp_dec(sp_q);
          end
        end
        default: ; // HOLD and reserved
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Falling-edge state registers
  // -------------------------------------------------------------------------
  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      sp_q  <= sp_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  // The stack write shares the edge with the sp update. The entry pushed at
  // this edge can therefore be popped at the very next edge.
  always_ff @(negedge i_clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_inc(pc_q);
    end
  end

  assign o_pc    = pc_q;
  assign o_sp    = sp_q;
  assign o_full  = full;
  assign o_empty = empty;
  assign o_ovf   = ovf_q;
  assign o_unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_SRST = 3'b011;
  localparam logic [2:0] OP_BREL = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  localparam int DEPTH = 8;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] target;
    logic [7:0]  offset;
    logic        stall;
    logic [15:0] exp_pc;
    logic [3:0]  exp_sp;
    logic [3:0]  exp_flags; // {full, empty, ovf, unf}
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  op;
  logic [15:0] target;
  logic [7:0]  offset;
`ifdef PC_STALL_EN
  logic        stall;
`endif
  logic [15:0] pc;
  logic [3:0]  sp;
  logic        full, empty, ovf, unf;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t sb[$];

  pc_stack_unit #(
    .PC_W(16), .OFF_W(8), .DEPTH(DEPTH), .RESET_VEC(16'h0000)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_op    (op),
    .i_target(target),
    .i_offset(offset),
`ifdef PC_STALL_EN
    .i_stall (stall),
`endif
    .o_pc    (pc),
    .o_sp    (sp),
    .o_full  (full),
    .o_empty (empty),
    .o_ovf   (ovf),
    .o_unf   (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one op away from the active (falling) edge and queue its expectation.
  // The outputs are sampled just after the falling edge and checked against
  // the popped entry.
  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    op = v.op; target = v.target; offset = v.offset;
`ifdef PC_STALL_EN
    stall = v.stall;
`endif
    sb.push_back(v);
    @(negedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, " pc"},    32'(pc), 32'(e.exp_pc));
    check({e.name, " sp"},    32'(sp), 32'(e.exp_sp));
    check({e.name, " flags"}, 32'({full, empty, ovf, unf}), 32'(e.exp_flags));
  endtask

  // Small reference model of the stack, used for the overflow/underflow run.
  logic [15:0] m_pc;
  logic        m_ovf, m_unf;
  logic [15:0] m_stk[$];

  function automatic vec_t model_step(input logic [2:0] o, input logic [15:0] t, input string nm);
    vec_t v;
    if (o == OP_CALL) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'd1);
      else m_ovf = 1'b1;
      m_pc = t;
    end else if (o == OP_RET) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_unf = 1'b1;
    end else if (o == OP_SRST) begin
      m_pc = 16'h0000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end
    v = '{o, t, 8'h00, 1'b0, m_pc, 4'(m_stk.size()),
          {m_stk.size() == DEPTH, m_stk.size() == 0, m_ovf, m_unf}, nm};
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{OP_INC,  16'h0000, 8'h00, 1'b0, 16'h0001, 4'd0, 4'b0100, "inc1"};
    tbl[1]  = '{OP_INC,  16'h0000, 8'h00, 1'b0, 16'h0002, 4'd0, 4'b0100, "inc2"};
    tbl[2]  = '{OP_INC,  16'h0000, 8'h00, 1'b0, 16'h0003, 4'd0, 4'b0100, "inc3"};
    tbl[3]  = '{OP_JMP,  16'hFFFF, 8'h00, 1'b0, 16'hFFFF, 4'd0, 4'b0100, "jmp_ffff"};
    tbl[4]  = '{OP_INC,  16'h0000, 8'h00, 1'b0, 16'h0000, 4'd0, 4'b0100, "inc_wrap"};
    tbl[5]  = '{OP_JMP,  16'h0002, 8'h00, 1'b0, 16'h0002, 4'd0, 4'b0100, "jmp_0002"};
    tbl[6]  = '{OP_BREL, 16'h0000, 8'hFC, 1'b0, 16'hFFFE, 4'd0, 4'b0100, "brel_neg"};
    tbl[7]  = '{OP_BREL, 16'h0000, 8'h05, 1'b0, 16'h0003, 4'd0, 4'b0100, "brel_pos"};
    tbl[8]  = '{OP_HOLD, 16'h1234, 8'h11, 1'b0, 16'h0003, 4'd0, 4'b0100, "hold"};
    tbl[9]  = '{OP_RSVD, 16'h1234, 8'h11, 1'b0, 16'h0003, 4'd0, 4'b0100, "reserved"};
    tbl[10] = '{OP_JMP,  16'h0010, 8'h00, 1'b0, 16'h0010, 4'd0, 4'b0100, "jmp_0010"};
    tbl[11] = '{OP_CALL, 16'h0100, 8'h00, 1'b0, 16'h0100, 4'd1, 4'b0000, "call_0100"};
    tbl[12] = '{OP_CALL, 16'h0200, 8'h00, 1'b0, 16'h0200, 4'd2, 4'b0000, "call_0200"};
    tbl[13] = '{OP_RET,  16'h0000, 8'h00, 1'b0, 16'h0101, 4'd1, 4'b0000, "ret_0101"};
    tbl[14] = '{OP_RET,  16'h0000, 8'h00, 1'b0, 16'h0011, 4'd0, 4'b0100, "ret_0011"};
    tbl[15] = '{OP_RET,  16'h0000, 8'h00, 1'b0, 16'h0011, 4'd0, 4'b0101, "ret_empty"};
    tbl[16] = '{OP_INC,  16'h0000, 8'h00, 1'b0, 16'h0012, 4'd0, 4'b0101, "unf_sticky"};
    tbl[17] = '{OP_SRST, 16'h0000, 8'h00, 1'b0, 16'h0000, 4'd0, 4'b0100, "srst1"};

    rst_n = 1'b0; op = OP_HOLD; target = '0; offset = '0;
`ifdef PC_STALL_EN
    stall = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset pc",    32'(pc),    32'h0000);
    check("reset sp",    32'(sp),    32'd0);
    check("reset full",  32'(full),  32'd0);
    check("reset empty", 32'(empty), 32'd1);
    check("reset ovf",   32'(ovf),   32'd0);
    check("reset unf",   32'(unf),   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) apply(tbl[i]);

    // Overflow: 9 calls into an 8-deep stack, then 9 returns.
    m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
    for (int i = 0; i < 9; i++)
      apply(model_step(OP_CALL, 16'h1000 + 16'(i * 16), $sformatf("ovf_call%0d", i)));
    check("ovf last target", 32'(pc), 32'h1080);
    for (int i = 0; i < 9; i++)
      apply(model_step(OP_RET, 16'h0000, $sformatf("lifo_ret%0d", i)));
    check("unf after 9th ret pc", 32'(pc), 32'h0001);
    apply(model_step(OP_SRST, 16'h0000, "srst2"));

    // Asynchronous reset between a CALL and its RET discards the stack.
    apply('{OP_CALL, 16'h0040, 8'h00, 1'b0, 16'h0040, 4'd1, 4'b0000, "call_0040"});
    @(posedge clk);
    op = OP_HOLD;
    rst_n = 1'b0;
    #1;
    check("async rst pc", 32'(pc), 32'h0000);
    check("async rst sp", 32'(sp), 32'd0);
    #1;
    rst_n = 1'b1;
    apply('{OP_RET, 16'h0000, 8'h00, 1'b0, 16'h0000, 4'd0, 4'b0101, "ret_after_rst"});

`ifdef PC_STALL_EN
    apply('{OP_CALL, 16'h0300, 8'h00, 1'b1, 16'h0000, 4'd0, 4'b0101, "stalled_call"});
    apply('{OP_CALL, 16'h0300, 8'h00, 1'b0, 16'h0300, 4'd1, 4'b0001, "unstalled_call"});
    apply('{OP_RET,  16'h0000, 8'h00, 1'b1, 16'h0300, 4'd1, 4'b0001, "stalled_ret"});
    apply('{OP_RET,  16'h0000, 8'h00, 1'b0, 16'h0001, 4'd0, 4'b0101, "unstalled_ret"});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
